memwb_stage_reg: RTL
====================

Name: memwb_stage_reg

Overview:
Parametrised MEM/WB pipeline register that replaces the fixed single-mux writeback latch in the CPU pipeline. It captures MEM-stage results on each rising clk edge. It selects one of four writeback sources, aligns and sign/zero-extends sub-word loads, and suppresses writes to x0. It adds a valid bit, stall/flush control, a misaligned-load flag and a registered forwarding view for the hazard unit.

Parameters:
XLEN, 32, datapath width in bits (32 or 64)
REG_AW, 5, register-file address width
FLUSH_CLEARS_DATA, 1, 1: flush zeroes wdata/rd; 0: flush clears only valid/regwrite

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-high (1 = reset) despite the name
in_valid  in  1  MEM-stage instruction is valid
stall  in  1  hold all registered outputs unchanged
flush  in  1  replace stage contents with a bubble
regwrite_i  in  1  instruction writes the register file
wb_sel_i  in  2  writeback source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM
load_type_i  in  3  RV funct3: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU (6 LWU, 3 LD only when XLEN=64)
addr_lo_i  in  3  low bits of the load address (ALU result)
mem_rdata_i  in  XLEN  raw aligned memory word
alu_result_i  in  XLEN  ALU result
pc_plus4_i  in  XLEN  link value
imm_i  in  XLEN  immediate (LUI)
rd_i  in  REG_AW  destination register
valid_o  out  1  stage holds a valid instruction
regwrite_o  out  1  register-file write enable
wdata_o  out  XLEN  writeback data
rd_o  out  REG_AW  writeback destination
misalign_o  out  1  registered misaligned-load flag
fwd_valid_o  out  1  equals valid_o & regwrite_o; for the hazard unit

Behaviour:
- Reset (rst_n=1, asynchronous): valid_o, regwrite_o, misalign_o and fwd_valid_o go to 0; wdata_o and rd_o go to 0. Reset is effective immediately, without waiting for a clock edge.
- Latency: exactly one rising edge from inputs to outputs. There is no negedge staging.
- Priority on each edge is reset > flush > stall > load.
- flush=1: valid_o, regwrite_o and misalign_o become 0. wdata_o and rd_o become 0 only if FLUSH_CLEARS_DATA=1. Flush wins when asserted together with stall.
- stall=1 with flush=0: every output holds its value.
- Load (stall=0, flush=0):
  - valid_o <= in_valid.
  - regwrite_o <= in_valid & regwrite_i & (rd_i != 0) & ~misalign.
  - rd_o <= rd_i.
  - wdata_o <= the selected source.
- in_valid=0 loads a bubble. regwrite_o and misalign_o are 0; data fields still load.
- MEM source path:
  - Byte lane = addr_lo_i × 8 within the word.
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - LW passes 32 bits, sign-extended when XLEN=64. LWU zero-extends; LD passes all 64 bits.
- Misalignment: set for LH/LHU with addr_lo_i[0]=1, LW/LWU with addr_lo_i[1:0]≠0, and LD with addr_lo_i≠0.
  - Flagged only when wb_sel_i=1 and in_valid=1.
  - A misaligned load has regwrite_o forced to 0, and wdata_o is 0.
- Unsupported load_type_i with wb_sel_i=1 yields wdata_o=0; it is not flagged.
- Only addr_lo_i[1:0] is used when XLEN=32.
- Non-MEM sources ignore load_type_i and addr_lo_i.
- fwd_valid_o is a registered copy consistent with valid_o & regwrite_o in every cycle, including reset and flush.

Decomposition:
- Shared package cpu_pkg holds:
  - WB_ALU/WB_MEM/WB_PC4/WB_IMM encodings.
  - LT_LB, LT_LH, LT_LW, LT_LD, LT_LBU, LT_LHU, LT_LWU funct3 constants.
  - The default XLEN.
- One combinational sub-module, load_extender: inputs are mem_rdata, addr_lo and load_type; outputs are extended data and a misalign flag. memwb_stage_reg instantiates it and adds the source mux and the register stage.

Test Plan:
- Reset mid-operation: drive valid traffic, raise rst_n between edges. All outputs must be 0 immediately, and remain 0 until the first edge after release.
- XLEN=32, LB with mem_rdata_i=0x80FF_7F01:
  - addr_lo=3 gives wdata_o=0xFFFF_FF80.
  - LBU with addr_lo=3 gives 0x0000_0080.
  - LH with addr_lo=2 gives 0xFFFF_80FF.
- Misaligned LW at addr_lo=2 with rd_i=7: misalign_o=1, regwrite_o=0, wdata_o=0, valid_o=1.
- rd_i=0, regwrite_i=1, wb_sel=ALU, alu_result=0x1234 → regwrite_o=0 and wdata_o=0x1234.
- Stall for 3 cycles with changing inputs → outputs frozen. Stall+flush on the same edge → valid_o=0, regwrite_o=0, fwd_valid_o=0.
- wb_sel=2 with pc_plus4=0x0000_0104, then wb_sel=3 with imm=0xABCD_E000, on back-to-back edges → wdata_o follows with one-cycle latency.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: writeback source encodings, load funct3 codes
// and the default datapath width.
package cpu_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LW  = 3'd2;
  localparam logic [2:0] LT_LD  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;
  localparam logic [2:0] LT_LWU = 3'd6;

endpackage

// File: rtl/load_extender.sv
// Combinational load alignment: picks the addressed byte lane, sign/zero-extends
// sub-word loads and flags misaligned accesses.
import cpu_pkg::*;

module load_extender #(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [2:0]      off;
  logic [XLEN-1:0] shifted;

  // A 32-bit word has only four byte lanes, so the top offset bit is ignored.
  assign off     = (XLEN == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
  assign shifted = mem_rdata >> {off, 3'b000};

  always_comb begin
    data     = '0;
    misalign = 1'b0;
    case (load_type)
      LT_LB:  data = XLEN'($signed(shifted[7:0]));
      LT_LBU: data = XLEN'(shifted[7:0]);
      LT_LH: begin
        misalign = off[0];
        data     = XLEN'($signed(shifted[15:0]));
      end
      LT_LHU: begin
        misalign = off[0];
        data     = XLEN'(shifted[15:0]);
      end
      LT_LW: begin
        misalign = (off[1:0] != 2'd0);
        data     = XLEN'($signed(shifted[31:0]));
      end
      LT_LWU: begin
        if (XLEN == 64) begin
          misalign = (off[1:0] != 2'd0);
          data     = XLEN'(shifted[31:0]);
        end
      end
      LT_LD: begin
        if (XLEN == 64) begin
          misalign = (off != 3'd0);
          data     = shifted;
        end
      end
      default: data = '0;
    endcase
    if (misalign) data = '0;
  end

endmodule

// File: rtl/memwb_stage_reg.sv
// MEM/WB pipeline register: writeback source mux, load extension, x0 write
// suppression, stall/flush control and a registered forwarding-valid view.
import cpu_pkg::*;

module memwb_stage_reg #(
  parameter int XLEN              = DEFAULT_XLEN,
  parameter int REG_AW            = 5,
  parameter bit FLUSH_CLEARS_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              regwrite_i,
  input  logic [1:0]        wb_sel_i,
  input  logic [2:0]        load_type_i,
  input  logic [2:0]        addr_lo_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   pc_plus4_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              valid_o,
  output logic              regwrite_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              misalign_o,
  output logic              fwd_valid_o
);

  logic [XLEN-1:0] ext_data;
  logic            ext_misalign;
  logic [XLEN-1:0] wdata_next;
  logic            misalign_next;
  logic            regwrite_next;

  load_extender #(.XLEN(XLEN)) u_load_extender (
    .mem_rdata (mem_rdata_i),
    .addr_lo   (addr_lo_i),
    .load_type (load_type_i),
    .data      (ext_data),
    .misalign  (ext_misalign)
  );

  always_comb begin
    wdata_next = '0;
    case (wb_sel_i)
      WB_ALU:  wdata_next = alu_result_i;
      WB_MEM:  wdata_next = ext_data;
      WB_PC4:  wdata_next = pc_plus4_i;
      WB_IMM:  wdata_next = imm_i;
      default: wdata_next = '0;
    endcase
  end

  // Bubbles never raise the flag, so a squashed load cannot trap.
  assign misalign_next = in_valid & (wb_sel_i == WB_MEM) & ext_misalign;
  assign regwrite_next = in_valid & regwrite_i & (rd_i != '0) & ~misalign_next;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid_o     <= 1'b0;
      regwrite_o  <= 1'b0;
      misalign_o  <= 1'b0;
      fwd_valid_o <= 1'b0;
      wdata_o     <= '0;
      rd_o        <= '0;
    end else if (flush) begin
      valid_o     <= 1'b0;
      regwrite_o  <= 1'b0;
      misalign_o  <= 1'b0;
      fwd_valid_o <= 1'b0;
      if (FLUSH_CLEARS_DATA) begin
        wdata_o <= '0;
        rd_o    <= '0;
      end
    end else if (!stall) begin
      valid_o     <= in_valid;
      regwrite_o  <= regwrite_next;
      misalign_o  <= misalign_next;
      fwd_valid_o <= regwrite_next;
      wdata_o     <= wdata_next;
      rd_o        <= rd_i;
    end
  end

endmodule
